// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock (LSB first) through a single Full_Adder cell.
// Optional subtract mode is built when the SERIAL_SUB_EN macro is defined.

module Full_Adder (
  output logic S,
  output logic C_out,
  input  logic A,
  input  logic B,
  input  logic C_in
);
  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               fa_s, fa_co;

  Full_Adder u_fa (
    .S     (fa_s),
    .C_out (fa_co),
    .A     (a_sr_q[0]),
    .B     (b_sr_q[0]),
    .C_in  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a_in;
`ifdef SERIAL_SUB_EN
          // Two's-complement subtract: invert B and inject a carry of one.
          b_sr_d  = sub ? ~b_in : b_in;
          carry_d = sub ? 1'b1 : c_in;
`else
          b_sr_d  = b_in;
          carry_d = c_in;
`endif
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == LAST) begin
          cout_d  = fa_co;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign sum_out = sum_q;
  assign c_out   = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed self-checking bench for serial_adder_seq (WIDTH=8); subtract vectors run when SERIAL_SUB_EN is defined.

module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       c_in = 1'b0;
`ifdef SERIAL_SUB_EN
  logic       sub = 1'b0;
`endif
  logic       busy, done, c_out;
  logic [7:0] sum_out;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  serial_adder_seq #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .c_in    (c_in),
`ifdef SERIAL_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .c_out   (c_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a start on the next edge, then wait (bounded) for done; leaves time at done+#1.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci, output int lat);
    a_in = a; b_in = b; c_in = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = 8'hC3; b_in = 8'h3C; c_in = ~ci;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] es, input logic ec);
    int lat;
    do_op(a, b, ci, lat);
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_sum"}, {24'b0, sum_out}, {24'b0, es});
    chk({tag, "_cout"}, {31'b0, c_out}, {31'b0, ec});
    @(posedge clk); #1;   // DONE -> IDLE; next start lands on the earliest legal edge
  endtask

  initial begin
    int lat, n_ops, done_base, pulses;
    logic [8:0] ref_v;

    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_sum", {24'b0, sum_out}, 0);
    chk("rst_cout", {31'b0, c_out}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op_check("t1", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    op_check("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op_check("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    op_check("t2c", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // start re-asserted on RUN edges 2-5 with different operands must be ignored
    a_in = 8'h5A; b_in = 8'h21; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_busy0", {31'b0, busy}, 1);
    @(posedge clk); #1;
    a_in = 8'hFF; b_in = 8'hFF; c_in = 1'b0; start = 1'b1;
    pulses = 0;
    for (int e = 2; e <= 8; e++) begin
      @(posedge clk); #1;
      if (e == 5) start = 1'b0;
      if (done === 1'b1) pulses++;
      if (e < 8) chk("t3_busy", {31'b0, busy}, 1);
    end
    chk("t3_done", {31'b0, done}, 1);
    chk("t3_sum", {24'b0, sum_out}, 32'h7C);
    chk("t3_cout", {31'b0, c_out}, 0);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk("t3_pulses", pulses, 1);
    chk("t3_hold_sum", {24'b0, sum_out}, 32'h7C);

    // asynchronous reset mid-RUN
    a_in = 8'hAA; b_in = 8'h55; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", {31'b0, busy}, 0);
    chk("t4_done", {31'b0, done}, 0);
    chk("t4_sum", {24'b0, sum_out}, 0);
    chk("t4_cout", {31'b0, c_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op_check("t4_after", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

`ifdef SERIAL_SUB_EN
    sub = 1'b1;
    op_check("t5a", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    op_check("t5b", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
    sub = 1'b0;
    op_check("t5c", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

    // strided sweep against a behavioural add, back-to-back starts
    n_ops = 0;
    done_base = done_cnt;
    for (int a = 0; a < 256; a += 17) begin
      for (int b = 0; b < 256; b += 15) begin
        for (int ci = 0; ci < 2; ci++) begin
          ref_v = 9'(a) + 9'(b) + 9'(ci);
          op_check("sweep", 8'(a), 8'(b), 1'(ci), ref_v[7:0], ref_v[8]);
          n_ops++;
        end
      end
    end
    chk("sweep_done_count", done_cnt - done_base, n_ops);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
